player_motion: RTL and testbench
================================

Name: player_motion

Overview:
- Parametrised player-character motion controller; next generation of the per-frame movement logic inside the screen draw loop.
- Owns an internal frame-tick divider, a jump/gravity state machine, clamped horizontal movement and a hazard-driven respawn sequence.
- Collision probes and hazard contact come from the background/projectile lookup blocks; pos_x/pos_y feed the character sprite renderer.

Parameters:
COORD_W, 9, width of all coordinates
TICK_DIV, 833333, clock cycles per motion tick (60 Hz at 50 MHz); must be >= 2
STEP_X, 1, horizontal pixels moved per tick
JUMP_HEIGHT, 40, pixels risen per jump before the fall starts
SPAWN_X, 35, spawn / reset x
SPAWN_Y, 205, spawn / reset y
MAX_X, 319, largest legal pos_x
MAX_Y, 239, falling to this y is a death (off screen)
RESPAWN_TICKS, 30, ticks spent frozen in RESPAWN

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
move_right  in  1  active-high, debounced
move_left  in  1  active-high, debounced
jump  in  1  active-high, debounced
blocked_left  in  1  probe left of sprite hits solid
blocked_right  in  1  probe right of sprite hits solid
blocked_up  in  1  probe above sprite hits solid
on_ground  in  1  probe below sprite hits solid
hit  in  1  hazard contact, may pulse for a single clock
pos_x  out  COORD_W  character x
pos_y  out  COORD_W  character y
state  out  2  00 GROUND, 01 RISE, 10 FALL, 11 RESPAWN
tick  out  1  one-clock strobe, high on the update cycle

Behaviour:
- Interface decision: one clock (clock); reset is synchronous and active-high.
- Reset values: pos_x=SPAWN_X, pos_y=SPAWN_Y, state=FALL, tick=0, tick counter=0, hit_pending=0, respawn counter=0. Reset has priority over everything, including mid-jump and mid-respawn.
- Tick divider:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 in the cycle where the counter equals TICK_DIV-1.
  - First tick occurs TICK_DIV cycles after reset deasserts.
- Update timing: all pos/state changes happen only on tick cycles; outputs are registered, so a new value appears the cycle after tick. Inputs are sampled on the tick cycle, except hit.
- hit handling:
  - hit sets hit_pending on any cycle.
  - hit_pending is consumed on the next tick and takes priority over all movement.
  - In RESPAWN, hit and hit_pending are ignored/cleared.
- Horizontal movement (tick, state != RESPAWN):
  - Only right active and !blocked_right: pos_x += STEP_X, clamped to MAX_X.
  - Only left active and !blocked_left: pos_x -= STEP_X, clamped to 0 (no underflow wrap).
  - Both or neither active: no move.
- Vertical FSM (per tick):
  - GROUND:
    - jump && on_ground: go to RISE; apex = pos_y - JUMP_HEIGHT, saturated at 0; pos_y unchanged this tick.
    - else !on_ground: go to FALL.
    - else: stay in GROUND.
  - RISE:
    - blocked_up: go to FALL, no y move.
    - else: pos_y -= 1; if the new pos_y == apex, go to FALL.
    - jump is ignored while rising; there is no double jump.
  - FALL:
    - on_ground: go to GROUND, no y move.
    - else: pos_y += 1; if the new pos_y >= MAX_Y, go to RESPAWN.
  - RESPAWN:
    - On entry: pos set to SPAWN_X/SPAWN_Y, counter=0.
    - On each tick: counter increments; inputs ignored.
    - When counter reaches RESPAWN_TICKS-1: go to FALL.
- Entry to RESPAWN via hit: same entry actions. Horizontal and vertical movement on that tick are suppressed.
- Simultaneous events on one tick:
  - hit + jump: RESPAWN.
  - jump + !on_ground in GROUND: FALL.
  - blocked_up on the same tick that apex is reached: FALL, no move.
- All arithmetic is COORD_W bits; clamps are computed before truncation.

Test Plan:
- TICK_DIV=4: release reset, hold inputs low -> tick high on cycles 4, 8, 12 after reset; state=FALL; pos_y 205→206→207 per tick with on_ground=0.
- on_ground=1 at pos_y=207, then jump for one tick -> RISE; pos_y falls by 1 per tick to 167; FALL on the tick pos_y hits 167; back to GROUND once on_ground=1.
- Rising from y=205, raise blocked_up at y=190 -> same tick goes to FALL, pos_y stays 190.
- pos_x=318, STEP_X=2, move_right held -> 319, then stays 319; pos_x=1 with move_left -> 0, never 511; both keys held -> no change.
- One-clock hit pulse mid-tick-period during RISE -> next tick state=RESPAWN, pos=(35,205); jump/move held for 30 ticks leaves pos unchanged; then state=FALL.
- Falling with on_ground=0 to y=239 -> RESPAWN. Assert reset during RESPAWN and during RISE -> next cycle pos=(35,205), state=FALL, tick counter restarts (first tick 4 cycles later).

Source files
------------

// File: rtl/player_motion.sv
// rtl/player_motion.sv - per-tick player motion: tick divider, jump/gravity FSM, clamped x, respawn
module player_motion #(
  parameter int COORD_W       = 9,
  parameter int TICK_DIV      = 833333,
  parameter int STEP_X        = 1,
  parameter int JUMP_HEIGHT   = 40,
  parameter int SPAWN_X       = 35,
  parameter int SPAWN_Y       = 205,
  parameter int MAX_X         = 319,
  parameter int MAX_Y         = 239,
  parameter int RESPAWN_TICKS = 30
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               move_right,
  input  logic               move_left,
  input  logic               jump,
  input  logic               blocked_left,
  input  logic               blocked_right,
  input  logic               blocked_up,
  input  logic               on_ground,
  input  logic               hit,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         state,
  output logic               tick
);

  localparam int TCNT_W = $clog2(TICK_DIV);
  localparam int RCNT_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;

  localparam logic [TCNT_W-1:0]  TICK_LAST = TCNT_W'(TICK_DIV - 1);
  localparam logic [RCNT_W-1:0]  RESP_LAST = RCNT_W'(RESPAWN_TICKS - 1);
  localparam logic [COORD_W:0]   STEP_W    = (COORD_W + 1)'(STEP_X);
  localparam logic [COORD_W:0]   JUMP_W    = (COORD_W + 1)'(JUMP_HEIGHT);
  localparam logic [COORD_W:0]   MAX_X_W   = (COORD_W + 1)'(MAX_X);
  localparam logic [COORD_W:0]   MAX_Y_W   = (COORD_W + 1)'(MAX_Y);
  localparam logic [COORD_W-1:0] SPAWN_X_C = COORD_W'(SPAWN_X);
  localparam logic [COORD_W-1:0] SPAWN_Y_C = COORD_W'(SPAWN_Y);

  typedef enum logic [1:0] {
    ST_GROUND  = 2'b00,
    ST_RISE    = 2'b01,
    ST_FALL    = 2'b10,
    ST_RESPAWN = 2'b11
  } state_t;

  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic               tick_q, tick_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic [COORD_W-1:0] apex_q, apex_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
  logic               hit_pending_q, hit_pending_d;
  state_t             state_q, state_d;

  logic [COORD_W:0]   x_right_sum;
  logic [COORD_W-1:0] x_right;
  logic [COORD_W-1:0] x_left;
  logic [COORD_W:0]   y_inc;
  logic [COORD_W-1:0] y_dec;

  // Free-running tick divider; tick is registered so it lines up with the counter's last value.
  always_comb begin
    tcnt_d = (tcnt_q == TICK_LAST) ? '0 : tcnt_q + TCNT_W'(1);
    tick_d = (tcnt_d == TICK_LAST);
  end

  // Wide arithmetic so clamps are decided before truncation to COORD_W.
  always_comb begin
    x_right_sum = {1'b0, pos_x_q} + STEP_W;
    x_right     = (x_right_sum > MAX_X_W) ? MAX_X_W[COORD_W-1:0] : x_right_sum[COORD_W-1:0];
    x_left      = ({1'b0, pos_x_q} < STEP_W) ? '0 : pos_x_q - STEP_W[COORD_W-1:0];
    y_inc       = {1'b0, pos_y_q} + (COORD_W + 1)'(1);
    y_dec       = pos_y_q - COORD_W'(1);
  end

  // Motion update: hit capture every cycle, position/state changes only on tick.
  always_comb begin
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    apex_d        = apex_q;
    rcnt_d        = rcnt_q;
    state_d       = state_q;
    hit_pending_d = (state_q == ST_RESPAWN) ? 1'b0 : (hit_pending_q | hit);

    if (tick_q) begin
      hit_pending_d = 1'b0;
      if (state_q == ST_RESPAWN) begin
        if (rcnt_q == RESP_LAST) begin
          state_d = ST_FALL;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end else if (hit_pending_q || hit) begin
        pos_x_d = SPAWN_X_C;
        pos_y_d = SPAWN_Y_C;
        rcnt_d  = '0;
        state_d = ST_RESPAWN;
      end else begin
        if (move_right && !move_left && !blocked_right) begin
          pos_x_d = x_right;
        end else if (move_left && !move_right && !blocked_left) begin
          pos_x_d = x_left;
        end

        case (state_q)
          ST_GROUND: begin
            if (jump && on_ground) begin
              state_d = ST_RISE;
              apex_d  = ({1'b0, pos_y_q} >= JUMP_W) ? pos_y_q - JUMP_W[COORD_W-1:0] : '0;
            end else if (!on_ground) begin
              state_d = ST_FALL;
            end
          end
          ST_RISE: begin
            // pos_y <= apex only happens when the jump started at the top edge; never wrap.
            if (blocked_up || (pos_y_q <= apex_q)) begin
              state_d = ST_FALL;
            end else begin
              pos_y_d = y_dec;
              if (y_dec == apex_q) begin
                state_d = ST_FALL;
              end
            end
          end
          ST_FALL: begin
            if (on_ground) begin
              state_d = ST_GROUND;
            end else if (y_inc >= MAX_Y_W) begin
              pos_x_d = SPAWN_X_C;
              pos_y_d = SPAWN_Y_C;
              rcnt_d  = '0;
              state_d = ST_RESPAWN;
            end else begin
              pos_y_d = y_inc[COORD_W-1:0];
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // State registers; reset overrides any jump or respawn in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt_q        <= '0;
      tick_q        <= 1'b0;
      pos_x_q       <= SPAWN_X_C;
      pos_y_q       <= SPAWN_Y_C;
      apex_q        <= '0;
      rcnt_q        <= '0;
      hit_pending_q <= 1'b0;
      state_q       <= ST_FALL;
    end else begin
      tcnt_q        <= tcnt_d;
      tick_q        <= tick_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      apex_q        <= apex_d;
      rcnt_q        <= rcnt_d;
      hit_pending_q <= hit_pending_d;
      state_q       <= state_d;
    end
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign state = state_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_player_motion.sv
// tb/tb_player_motion.sv - directed scoreboard bench for player_motion
module tb_player_motion;

  localparam int GROUND  = 0;
  localparam int RISE    = 1;
  localparam int FALL    = 2;
  localparam int RESPAWN = 3;

  logic       clock;
  logic       reset;
  logic       move_right, move_left, jump;
  logic       blocked_left, blocked_right, blocked_up, on_ground, hit;
  logic [8:0] pos_x, pos_y;
  logic [1:0] state;
  logic       tick;

  typedef struct {
    string tag;
    int    x;
    int    y;
    int    st;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  player_motion #(
    .TICK_DIV (4),
    .STEP_X   (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .move_right    (move_right),
    .move_left     (move_left),
    .jump          (jump),
    .blocked_left  (blocked_left),
    .blocked_right (blocked_right),
    .blocked_up    (blocked_up),
    .on_ground     (on_ground),
    .hit           (hit),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .state         (state),
    .tick          (tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance until tick is high (sampled #1 after an edge); returns cycles waited.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    while (tick !== 1'b1 && cycles < 20) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    if (tick !== 1'b1) begin
      n_assert++;
      n_fail++;
      $error("FAIL tick_timeout observed=%0b expected=1", tick);
    end
  endtask

  // Push the expected post-tick result, let the tick happen, then pop and compare.
  task automatic step(input string tag, input int ex, input int ey, input int est);
    int   c;
    exp_t e;
    sb.push_back('{tag, ex, ey, est});
    wait_tick(c);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({e.tag, "_x"}, 32'(pos_x), 32'(e.x));
    check({e.tag, "_y"}, 32'(pos_y), 32'(e.y));
    check({e.tag, "_st"}, 32'(state), 32'(e.st));
  endtask

  // Called in the first cycle after reset releases; that cycle is cycle 1.
  task automatic check_reset(input string tag);
    int c;
    check({tag, "_x"}, 32'(pos_x), 32'd35);
    check({tag, "_y"}, 32'(pos_y), 32'd205);
    check({tag, "_st"}, 32'(state), 32'(FALL));
    check({tag, "_tick"}, 32'(tick), 32'd0);
    wait_tick(c);
    check({tag, "_first_tick_cycle"}, 32'(c + 1), 32'd4);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset(tag);
  endtask

  task automatic pulse_hit();
    @(posedge clock);
    #1;
    hit = 1'b1;
    @(posedge clock);
    #1;
    hit = 1'b0;
  endtask

  initial begin
    int c;
    move_right = 0; move_left = 0; jump = 0;
    blocked_left = 0; blocked_right = 0; blocked_up = 0; on_ground = 0; hit = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset("por");

    step("fall1", 35, 206, FALL);
    wait_tick(c);
    check("tick_period", 32'(c + 1), 32'd4);
    step("fall2", 35, 207, FALL);

    on_ground = 1;
    step("land", 35, 207, GROUND);
    jump = 1;
    step("jump", 35, 207, RISE);
    for (int y = 206; y >= 168; y--) step("rise", 35, y, RISE);
    step("apex", 35, 167, FALL);
    jump = 0;
    step("land2", 35, 167, GROUND);

    move_left = 1;
    for (int x = 33; x >= 1; x -= 2) step("left", x, 167, GROUND);
    step("left_clamp", 0, 167, GROUND);
    step("left_hold", 0, 167, GROUND);
    move_right = 1;
    step("both_keys", 0, 167, GROUND);
    move_left = 0;
    for (int x = 2; x <= 318; x += 2) step("right", x, 167, GROUND);
    step("right_clamp", 319, 167, GROUND);
    step("right_hold", 319, 167, GROUND);
    move_right = 0; move_left = 1; blocked_left = 1;
    step("blocked_left", 319, 167, GROUND);
    blocked_left = 0;
    step("left2", 317, 167, GROUND);
    move_left = 0; move_right = 1; blocked_right = 1;
    step("blocked_right", 317, 167, GROUND);
    blocked_right = 0; move_right = 0;

    jump = 1;
    step("jump2", 317, 167, RISE);
    jump = 0;
    step("rise2", 317, 166, RISE);
    pulse_hit();
    jump = 1; move_right = 1;
    step("hit", 35, 205, RESPAWN);
    for (int i = 1; i <= 29; i++) begin
      if (i == 10) pulse_hit();
      step("respawn", 35, 205, RESPAWN);
    end
    step("respawn_exit", 35, 205, FALL);
    jump = 0; move_right = 0; on_ground = 0;
    step("no_stale_hit", 35, 206, FALL);

    for (int y = 207; y <= 238; y++) step("fall", 35, y, FALL);
    step("fall_death", 35, 205, RESPAWN);

    @(posedge clock);
    #1;
    pulse_reset("rst_respawn");

    on_ground = 1;
    step("land3", 35, 205, GROUND);
    jump = 1;
    step("jump3", 35, 205, RISE);
    jump = 0;
    for (int y = 204; y >= 190; y--) step("rise3", 35, y, RISE);
    blocked_up = 1;
    step("blocked_up", 35, 190, FALL);
    blocked_up = 0;
    step("land4", 35, 190, GROUND);
    jump = 1;
    step("jump4", 35, 190, RISE);
    jump = 0;
    step("rise4", 35, 189, RISE);
    repeat (2) @(posedge clock);
    #1;
    pulse_reset("rst_rise");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
